pwm_deadtime_gen: RTL

- Output stage directly downstream of the free-running PWM period counter.
- Compares the counter value against a double-buffered duty register and produces complementary high-side/low-side gate drives with programmable dead time.
- Duty updates arrive over a valid/ready handshake and take effect only at the period boundary, so no pulse is ever truncated or doubled.

---
 rtl/pwm_deadtime_gen.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM output stage with double-buffered duty and programmable dead time.
// Optional macro PWM_UPDATE_IRQ_EN adds upd_irq, a one-cycle pulse on each duty commit.
module pwm_deadtime_gen #(
  parameter int N    = 10,
  parameter int TOP  = 511,
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    count_in,
  input  logic            enable,
  input  logic [DT_W-1:0] dead_time,
  input  logic [N-1:0]    duty_data,
  input  logic            duty_valid,
  output logic            duty_ready,
  output logic [N-1:0]    duty_active,
  output logic            pwm_h,
  output logic            pwm_l
`ifdef PWM_UPDATE_IRQ_EN
  ,
  output logic            upd_irq
`endif
);

  typedef enum logic [1:0] {
    S_OFF,
    S_DT_RISE,
    S_ON,
    S_DT_FALL
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [DT_W-1:0] r_dt_cnt;
  logic [DT_W-1:0] w_dt_nxt;
  logic [DT_W-1:0] w_dt_load;
  logic            r_pending;
  logic [N-1:0]    r_pend_val;
  logic [N-1:0]    r_duty_active;
  logic            r_pwm_h;
  logic            r_pwm_l;
  logic            w_boundary;
  logic            w_accept;
  logic            w_commit;
  logic            w_raw_on;

  assign w_boundary = (count_in == N'(TOP));
  assign w_accept   = duty_valid & ~r_pending;
  assign w_commit   = w_boundary & r_pending;
  assign w_raw_on   = enable & (count_in < r_duty_active);
  assign w_dt_load  = dead_time - DT_W'(1);

  assign duty_ready  = ~r_pending;
  assign duty_active = r_duty_active;
  assign pwm_h       = r_pwm_h;
  assign pwm_l       = r_pwm_l;

  // Accept and commit are mutually exclusive: accept needs pending=0, commit needs pending=1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pending     <= 1'b0;
      r_pend_val    <= '0;
      r_duty_active <= '0;
    end else if (w_commit) begin
      r_duty_active <= r_pend_val;
      r_pending     <= 1'b0;
    end else if (w_accept) begin
      r_pend_val    <= duty_data;
      r_pending     <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dt_nxt    = r_dt_cnt;
    case (r_state)
      S_OFF: begin
        if (w_raw_on) begin
          if (dead_time == '0) begin
            w_state_nxt = S_ON;
          end else begin
            w_state_nxt = S_DT_RISE;
            w_dt_nxt    = w_dt_load;
          end
        end
      end
      S_DT_RISE: begin
        if (!w_raw_on) begin
          w_state_nxt = S_OFF;
        end else if (r_dt_cnt == '0) begin
          w_state_nxt = S_ON;
        end else begin
          w_dt_nxt = r_dt_cnt - DT_W'(1);
        end
      end
      S_ON: begin
        if (!w_raw_on) begin
          if (dead_time == '0) begin
            w_state_nxt = S_OFF;
          end else begin
            w_state_nxt = S_DT_FALL;
            w_dt_nxt    = w_dt_load;
          end
        end
      end
      S_DT_FALL: begin
        // A zero dead time here (only reachable from reset) goes straight to ON rather than wrapping the reload.
        if (w_raw_on) begin
          if (dead_time == '0) begin
            w_state_nxt = S_ON;
          end else begin
            w_state_nxt = S_DT_RISE;
            w_dt_nxt    = w_dt_load;
          end
        end else if (r_dt_cnt == '0) begin
          w_state_nxt = S_OFF;
        end else begin
          w_dt_nxt = r_dt_cnt - DT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_DT_FALL;
        w_dt_nxt    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_DT_FALL;
      r_dt_cnt <= '0;
      r_pwm_h  <= 1'b0;
      r_pwm_l  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dt_cnt <= w_dt_nxt;
      r_pwm_h  <= (w_state_nxt == S_ON);
      r_pwm_l  <= (w_state_nxt == S_OFF);
    end
  end

`ifdef PWM_UPDATE_IRQ_EN
  logic r_upd_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upd_irq <= 1'b0;
    end else begin
      r_upd_irq <= w_commit;
    end
  end

  assign upd_irq = r_upd_irq;
`endif

endmodule
